// File: rtl/spi_cfg_controller.sv
// Round-robin arbiter for two register-write requesters.
// Each accepted legal request is sent as a 16-bit mode-0 SPI write frame: flag, addr[6:0], data[7:0].
module spi_cfg_controller #(
  parameter int   CLK_DIV  = 4,
  parameter int   GAP_CYC  = 8,
  parameter int   MAX_ADDR = 4,
  parameter logic WR_FLAG  = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  input  logic [6:0] req0_addr,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [6:0] req1_addr,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic       grant_id,
  output logic       busy,
  output logic       done,
  output logic       err_addr,
  output logic       sclk,
  output logic       copi,
  output logic       ncs
);

  localparam int CNT_MAX = (CLK_DIV > GAP_CYC) ? CLK_DIV : GAP_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYC - 1);
  localparam logic [6:0]       MAX_A    = 7'(MAX_ADDR);

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, GAP} state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] div_cnt_reg, div_cnt_next;
  logic [3:0]       bit_idx_reg, bit_idx_next;
  logic [14:0]      frame_reg, frame_next;
  logic             sclk_reg, sclk_next;
  logic             copi_reg, copi_next;
  logic             ncs_reg, ncs_next;
  logic             done_reg, done_next;
  logic             err_reg, err_next;
  logic             grant_reg, grant_next;
  logic             last_reg, last_next;

  logic [1:0] valid_vec;
  logic [1:0] sel_vec;
  logic [1:0] ready_vec;
  logic       hs;
  logic       hs_id;
  logic [6:0] hs_addr;
  logic [7:0] hs_data;

  assign valid_vec = {req1_valid, req0_valid};

  for (genvar gi = 0; gi < 2; gi++) begin : g_sel
    // A requester wins when alone, or when the other one owned the previous grant.
    assign sel_vec[gi]   = valid_vec[gi] && (!valid_vec[1-gi] || (last_reg == 1'(1 - gi)));
    assign ready_vec[gi] = (state_reg == IDLE) && sel_vec[gi];
  end

  assign req0_ready = ready_vec[0];
  assign req1_ready = ready_vec[1];
  assign hs         = |ready_vec;
  assign hs_id      = ready_vec[1];
  assign hs_addr    = hs_id ? req1_addr : req0_addr;
  assign hs_data    = hs_id ? req1_data : req0_data;

  always_comb begin
    state_next   = state_reg;
    div_cnt_next = div_cnt_reg;
    bit_idx_next = bit_idx_reg;
    frame_next   = frame_reg;
    sclk_next    = sclk_reg;
    copi_next    = copi_reg;
    ncs_next     = ncs_reg;
    done_next    = 1'b0;
    err_next     = 1'b0;
    grant_next   = grant_reg;
    last_next    = last_reg;
    case (state_reg)
      IDLE: begin
        if (hs) begin
          grant_next = hs_id;
          last_next  = hs_id;
          if (hs_addr > MAX_A) begin
            err_next = 1'b1;
          end else begin
            frame_next   = {hs_addr, hs_data};
            copi_next    = WR_FLAG;
            ncs_next     = 1'b0;
            sclk_next    = 1'b0;
            div_cnt_next = '0;
            bit_idx_next = 4'd0;
            state_next   = SETUP;
          end
        end
      end
      SETUP: begin
        if (div_cnt_reg == DIV_LAST) begin
          div_cnt_next = '0;
          sclk_next    = 1'b1;
          state_next   = SHIFT;
        end else begin
          div_cnt_next = div_cnt_reg + CNT_W'(1);
        end
      end
      SHIFT: begin
        if (div_cnt_reg == DIV_LAST) begin
          div_cnt_next = '0;
          if (sclk_reg) begin
            sclk_next    = 1'b0;
            bit_idx_next = bit_idx_reg + 4'd1;
            if (bit_idx_reg != 4'd15) begin
              copi_next  = frame_reg[14];
              frame_next = {frame_reg[13:0], 1'b0};
            end
          end else if (bit_idx_reg == 4'd0) begin
            // bit_idx has wrapped: this was the low phase after the 16th falling edge
            ncs_next   = 1'b1;
            copi_next  = 1'b0;
            done_next  = 1'b1;
            state_next = GAP;
          end else begin
            sclk_next = 1'b1;
          end
        end else begin
          div_cnt_next = div_cnt_reg + CNT_W'(1);
        end
      end
      GAP: begin
        if (div_cnt_reg == GAP_LAST) begin
          div_cnt_next = '0;
          state_next   = IDLE;
        end else begin
          div_cnt_next = div_cnt_reg + CNT_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      div_cnt_reg <= '0;
      bit_idx_reg <= 4'd0;
      frame_reg   <= '0;
      sclk_reg    <= 1'b0;
      copi_reg    <= 1'b0;
      ncs_reg     <= 1'b1;
      done_reg    <= 1'b0;
      err_reg     <= 1'b0;
      grant_reg   <= 1'b0;
      last_reg    <= 1'b1;
    end else begin
      state_reg   <= state_next;
      div_cnt_reg <= div_cnt_next;
      bit_idx_reg <= bit_idx_next;
      frame_reg   <= frame_next;
      sclk_reg    <= sclk_next;
      copi_reg    <= copi_next;
      ncs_reg     <= ncs_next;
      done_reg    <= done_next;
      err_reg     <= err_next;
      grant_reg   <= grant_next;
      last_reg    <= last_next;
    end
  end

  assign busy     = (state_reg != IDLE);
  assign done     = done_reg;
  assign err_addr = err_reg;
  assign grant_id = grant_reg;
  assign sclk     = sclk_reg;
  assign copi     = copi_reg;
  assign ncs      = ncs_reg;

endmodule

// File: tb/tb_spi_cfg_controller.sv
// Bench for spi_cfg_controller: instance 0 runs CLK_DIV=4, instance 1 runs CLK_DIV=7.
// Expected frames are queued by the stimulus; per-instance monitors decode the SPI pins and compare.
module tb_spi_cfg_controller;

  localparam int GAP = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] v0, v1;
  logic [6:0] a0 [2];
  logic [6:0] a1 [2];
  logic [7:0] d0 [2];
  logic [7:0] d1 [2];
  logic [1:0] rdy0, rdy1, gid, busy, done, err, sclk, copi, ncs;

  int n_checks = 0;
  int n_errors = 0;
  int hs_cnt [2];
  int err_cnt [2];

  // {instance, grant id, 16-bit frame}
  logic [17:0] exp_q [$];

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    localparam int CD = (gi == 0) ? 4 : 7;

    spi_cfg_controller #(
      .CLK_DIV (CD),
      .GAP_CYC (GAP),
      .MAX_ADDR(4),
      .WR_FLAG (1'b0)
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req0_valid(v0[gi]),
      .req0_addr (a0[gi]),
      .req0_data (d0[gi]),
      .req0_ready(rdy0[gi]),
      .req1_valid(v1[gi]),
      .req1_addr (a1[gi]),
      .req1_data (d1[gi]),
      .req1_ready(rdy1[gi]),
      .grant_id  (gid[gi]),
      .busy      (busy[gi]),
      .done      (done[gi]),
      .err_addr  (err[gi]),
      .sclk      (sclk[gi]),
      .copi      (copi[gi]),
      .ncs       (ncs[gi])
    );

    logic        prev_ncs, prev_sclk, prev_copi, rise_copi, in_frame, had_frame, frame_end;
    int          low_cnt, run_len, nbits, gap_cnt;
    logic [15:0] bits;
    logic [17:0] e;

    initial begin
      prev_ncs = 1'b1; prev_sclk = 1'b0; prev_copi = 1'b0; rise_copi = 1'b0;
      in_frame = 1'b0; had_frame = 1'b0;
      low_cnt = 0; run_len = 0; nbits = 0; gap_cnt = 0; bits = '0;
      hs_cnt[gi] = 0; err_cnt[gi] = 0;
      forever begin
        @(negedge clk);
        frame_end = 1'b0;
        if (!rst_n) begin
          prev_ncs = 1'b1; prev_sclk = 1'b0; prev_copi = 1'b0;
          in_frame = 1'b0; had_frame = 1'b0;
        end else begin
          if (rdy0[gi] || rdy1[gi]) check("ready_only_idle", int'(busy[gi]), 0);
          if (v0[gi] && rdy0[gi]) hs_cnt[gi]++;
          if (v1[gi] && rdy1[gi]) hs_cnt[gi]++;
          if (err[gi]) begin
            err_cnt[gi]++;
            check("err_ncs_high", int'(ncs[gi]), 1);
            check("err_not_busy", int'(busy[gi]), 0);
          end
          if (ncs[gi]) check("sclk_idle_ncs_high", int'(sclk[gi]), 0);
          if (!ncs[gi] && prev_ncs) begin
            if (had_frame) check("gap_min", int'(gap_cnt >= GAP), 1);
            check("start_sclk_low", int'(sclk[gi]), 0);
            in_frame = 1'b1; low_cnt = 1; run_len = 1; nbits = 0; bits = '0;
          end else if (!ncs[gi] && in_frame) begin
            low_cnt++;
            if (sclk[gi] != prev_sclk) begin
              check("half_period", run_len, CD);
              run_len = 1;
              if (sclk[gi]) begin
                bits = {bits[14:0], copi[gi]};
                nbits++;
                rise_copi = copi[gi];
              end else begin
                check("copi_stable_high", int'(prev_copi), int'(rise_copi));
              end
            end else begin
              run_len++;
            end
          end else if (ncs[gi] && !prev_ncs && in_frame) begin
            frame_end = 1'b1;
            check("last_low_phase", run_len, CD);
            check("ncs_low_cycles", low_cnt, 33 * CD);
            check("rise_count", nbits, 16);
            check("done_at_end", int'(done[gi]), 1);
            check("copi_idle", int'(copi[gi]), 0);
            if (exp_q.size() > 0) begin
              e = exp_q.pop_front();
              check("frame_instance", gi, int'(e[17]));
              check("grant_id", int'(gid[gi]), int'(e[16]));
              check("frame_bits", int'(bits), int'(e[15:0]));
            end else begin
              n_checks++;
              n_errors++;
              $display("FAIL unexpected_frame: inst %0d frame 0x%04h, expected none", gi, bits);
            end
            in_frame = 1'b0; had_frame = 1'b1; gap_cnt = 1;
          end else if (ncs[gi]) begin
            gap_cnt++;
          end
          if (!frame_end) check("done_only_at_end", int'(done[gi]), 0);
          prev_ncs = ncs[gi]; prev_sclk = sclk[gi]; prev_copi = copi[gi];
        end
      end
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Called 1 time unit after a rising edge; returns 1 time unit after the handshake edge.
  task automatic send(input int inst, input bit id, input logic [6:0] a, input logic [7:0] d,
                      input bit keep);
    bit got;
    got = 1'b0;
    if (id) begin
      v1[inst] = 1'b1; a1[inst] = a; d1[inst] = d;
    end else begin
      v0[inst] = 1'b1; a0[inst] = a; d0[inst] = d;
    end
    for (int i = 0; i < 4000 && !got; i++) begin
      @(negedge clk);
      got = id ? rdy1[inst] : rdy0[inst];
    end
    check("handshake", int'(got), 1);
    @(posedge clk);
    #1;
    if (!keep) begin
      if (id) v1[inst] = 1'b0;
      else    v0[inst] = 1'b0;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 6000 && (exp_q.size() != 0 || busy != 2'b00); i++) sync();
    check("drain", exp_q.size(), 0);
  endtask

  task automatic pulse_reset();
    sync();
    rst_n = 1'b0;
    sync();
    rst_n = 1'b1;
  endtask

  initial begin
    time t2, t3;
    int  rises;
    logic ps;
    rst_n = 1'b0;
    v0 = '0;
    v1 = '0;
    for (int i = 0; i < 2; i++) begin
      a0[i] = '0; a1[i] = '0; d0[i] = '0; d1[i] = '0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("rst_ncs", int'(ncs[i]), 1);
      check("rst_sclk", int'(sclk[i]), 0);
      check("rst_copi", int'(copi[i]), 0);
      check("rst_busy", int'(busy[i]), 0);
      check("rst_done", int'(done[i]), 0);
      check("rst_err", int'(err[i]), 0);
      check("rst_grant", int'(gid[i]), 0);
    end
    sync();
    rst_n = 1'b1;

    // Single write: flag 0, addr 4, data 0x80
    exp_q.push_back({1'b0, 1'b0, 16'h0480});
    sync();
    send(0, 1'b0, 7'd4, 8'h80, 1'b0);
    drain();

    // Contention after reset: grants 0,1 then 0,1 again
    pulse_reset();
    exp_q.push_back({1'b0, 1'b0, 16'h013C});
    exp_q.push_back({1'b0, 1'b1, 16'h02A5});
    fork
      send(0, 1'b0, 7'd1, 8'h3C, 1'b0);
      send(0, 1'b1, 7'd2, 8'hA5, 1'b0);
    join
    drain();
    exp_q.push_back({1'b0, 1'b0, 16'h035A});
    exp_q.push_back({1'b0, 1'b1, 16'h00FF});
    fork
      send(0, 1'b0, 7'd3, 8'h5A, 1'b0);
      send(0, 1'b1, 7'd0, 8'hFF, 1'b0);
    join
    drain();

    // Out-of-range addresses are dropped
    send(0, 1'b1, 7'd5, 8'h00, 1'b0);
    @(negedge clk);
    check("drop_err_pulse", int'(err[0]), 1);
    check("drop_busy", int'(busy[0]), 0);
    check("drop_ncs", int'(ncs[0]), 1);
    check("drop_grant", int'(gid[0]), 1);
    @(negedge clk);
    check("drop_err_single", int'(err[0]), 0);
    sync();
    send(0, 1'b1, 7'h7F, 8'h00, 1'b1);
    t2 = $time;
    send(0, 1'b1, 7'h06, 8'h00, 1'b0);
    t3 = $time;
    check("b2b_drop_cycles", int'((t3 - t2) / 10), 1);
    send(0, 1'b0, 7'h40, 8'h00, 1'b0);
    @(negedge clk);
    check("drop_err_req0", int'(err[0]), 1);
    check("drop_grant_req0", int'(gid[0]), 0);
    sync();

    // req0 valid held continuously across three frames
    exp_q.push_back({1'b0, 1'b0, 16'h0411});
    exp_q.push_back({1'b0, 1'b0, 16'h0222});
    exp_q.push_back({1'b0, 1'b0, 16'h0133});
    send(0, 1'b0, 7'd4, 8'h11, 1'b1);
    send(0, 1'b0, 7'd2, 8'h22, 1'b1);
    send(0, 1'b0, 7'd1, 8'h33, 1'b0);
    drain();

    // Asynchronous reset after the 7th sclk rise (copi carries addr[1]=1 there)
    send(0, 1'b0, 7'd3, 8'h5A, 1'b0);
    rises = 0;
    ps = 1'b0;
    for (int i = 0; i < 2000 && rises < 7; i++) begin
      @(negedge clk);
      if (sclk[0] && !ps) rises++;
      ps = sclk[0];
    end
    check("rise_wait", rises, 7);
    check("pre_reset_copi", int'(copi[0]), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_ncs", int'(ncs[0]), 1);
    check("async_rst_sclk", int'(sclk[0]), 0);
    check("async_rst_copi", int'(copi[0]), 0);
    check("async_rst_busy", int'(busy[0]), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.push_back({1'b0, 1'b0, 16'h0001});
    exp_q.push_back({1'b0, 1'b1, 16'h04FE});
    fork
      send(0, 1'b0, 7'd0, 8'h01, 1'b0);
      send(0, 1'b1, 7'd4, 8'hFE, 1'b0);
    join
    drain();

    // CLK_DIV=7 instance, alternating data bits
    exp_q.push_back({1'b1, 1'b0, 16'h0255});
    send(1, 1'b0, 7'd2, 8'h55, 1'b0);
    drain();

    repeat (4) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    check("err_count_inst0", err_cnt[0], 4);
    check("err_count_inst1", err_cnt[1], 0);
    check("hs_count_inst0", hs_cnt[0], 15);
    check("hs_count_inst1", hs_cnt[1], 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
